cabac_bina_serializer: RTL and testbench

- Downstream of the binarization-type lookup in the CABAC front end.
- Takes one syntax element per handshake: value, binarization type, cMax, ctxIdx and Rice parameter.
- Emits its bin string one bin per cycle, MSB/prefix first, to the bin-to-context/arithmetic-coder stage.
- Tags each bin with bypass flag, ctxIdx, bin index and a last marker.

---
 rtl/cabac_bina_pkg.sv | 14 +
 rtl/cabac_bina_egk_step.sv | 18 +
 rtl/cabac_bina_serializer.sv | 172 +++++++++++++++++
 tb/tb_cabac_bina_serializer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cabac_bina_pkg.sv
// cabac_bina_pkg: binarization type codes and shared constants for the CABAC front end
package cabac_bina_pkg;
  localparam logic [2:0] FL   = 3'd0;
  localparam logic [2:0] TU   = 3'd1;
  localparam logic [2:0] EG1  = 3'd2;
  localparam logic [2:0] CREG = 3'd4;
  localparam logic [2:0] SP   = 3'd5;
  localparam logic [8:0] BYPASS_CTX = 9'd187;
  typedef enum logic [1:0] {IDLE, PREFIX, SUFFIX} state_e;
  typedef enum logic [1:0] {MD_UNARY, MD_EGK, MD_BITS} mode_e;
  function automatic logic [2:0] bit_len(input logic [3:0] x);
    bit_len = x[3] ? 3'd4 : x[2] ? 3'd3 : x[1] ? 3'd2 : x[0] ? 3'd1 : 3'd0;
  endfunction
endpackage

// File: rtl/cabac_bina_egk_step.sv
// cabac_bina_egk_step: one step of an Exp-Golomb prefix (emit 1 and consume 1<<k, or terminate)
module cabac_bina_egk_step #(
  parameter int W = 17
) (
  input  logic [W-1:0] val_i,
  input  logic [4:0]   k_i,
  output logic         bin_o,
  output logic [W-1:0] val_o,
  output logic [4:0]   k_o,
  output logic         prefix_done_o
);
  logic [W-1:0] step;
  assign step = W'(1) << k_i;
  assign bin_o = val_i >= step;
  assign val_o = bin_o ? val_i - step : val_i;
  assign k_o = bin_o ? k_i + 5'd1 : k_i;
  assign prefix_done_o = !bin_o;
endmodule

// File: rtl/cabac_bina_serializer.sv
// cabac_bina_serializer: serializes one binarized syntax element into tagged bins, one per cycle
module cabac_bina_serializer
  import cabac_bina_pkg::*;
#(
  parameter int VAL_W     = 16,
  parameter int BIN_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_binaType,
  input  logic [3:0]           in_cMax,
  input  logic [8:0]           in_ctxIdx,
  input  logic [VAL_W-1:0]     in_value,
  input  logic [2:0]           in_rice,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_bin,
  output logic                 out_bypass,
  output logic [8:0]           out_ctxIdx,
  output logic [BIN_IDX_W-1:0] out_binIdx,
  output logic                 out_last
);
  localparam int VW = VAL_W + 1;
  state_e state_q, state_d, ph;
  mode_e md_q, md_d, i_md, p_md;
  logic [5:0] n_q, n_d, i_n, p_n;
  logic [VW-1:0] v_q, v_d, i_v, p_v, e_v, val_x, esc_v;
  logic [4:0] k_q, k_d, i_k, p_k, e_k;
  logic [2:0] sn_q, i_sn, p_sn;
  logic term_q, i_term, p_term, esc_q, i_esc, p_esc, sfx_q, sfx_d, p_sfx;
  logic bin_q, bin_d, last_q, last_d, byp_q, e_bin, e_done;
  logic accept, xfer, load, zero, type_ok;
  logic [8:0] ctx_q;
  logic [BIN_IDX_W-1:0] idx_q;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q != IDLE;
  assign out_bin = bin_q;
  assign out_bypass = byp_q;
  assign out_ctxIdx = ctx_q;
  assign out_binIdx = idx_q;
  assign out_last = last_q;
  assign accept = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  assign load = (accept && !zero) || (xfer && !last_q);
  // Initial generator position decoded straight from the element fields
  always_comb begin
    val_x = VW'(in_value);
    esc_v = val_x - (VW'(4) << in_rice);
    type_ok = in_binaType inside {FL, TU, EG1, CREG, SP};
    zero = !type_ok || ((in_binaType inside {FL, TU, SP}) && in_cMax == 4'd0);
    i_md = MD_BITS;
    i_n = '0;
    i_term = 1'b0;
    i_esc = 1'b0;
    i_sn = '0;
    i_v = val_x;
    i_k = 5'd1;
    case (in_binaType)
      FL: i_n = 6'(bit_len(in_cMax));
      SP: i_n = 6'(in_cMax);
      TU: begin
        i_md = MD_UNARY;
        i_term = val_x < VW'(in_cMax);
        i_n = i_term ? 6'(in_value) : 6'(in_cMax);
      end
      EG1: i_md = MD_EGK;
      CREG: begin
        i_md = MD_UNARY;
        if (val_x < (VW'(4) << in_rice)) begin
          i_n = 6'(val_x >> in_rice);
          i_term = 1'b1;
          i_sn = in_rice;
        end else begin
          i_n = 6'd4;
          i_esc = 1'b1;
          i_v = esc_v;
          i_k = 5'(in_rice) + 5'd1;
        end
      end
      default: ;
    endcase
  end
  assign p_md = accept ? i_md : md_q;
  assign p_n = accept ? i_n : n_q;
  assign p_v = accept ? i_v : v_q;
  assign p_k = accept ? i_k : k_q;
  assign p_sn = accept ? i_sn : sn_q;
  assign p_term = accept ? i_term : term_q;
  assign p_esc = accept ? i_esc : esc_q;
  assign p_sfx = accept ? 1'b0 : sfx_q;
  cabac_bina_egk_step #(.W(VW)) u_egk (
    .val_i(p_v), .k_i(p_k), .bin_o(e_bin), .val_o(e_v), .k_o(e_k), .prefix_done_o(e_done)
  );
  // Produce the bin at the current position and advance to the next one
  always_comb begin
    bin_d = |(p_v & (VW'(1) << (p_n - 6'd1)));
    last_d = p_n == 6'd1;
    md_d = p_md;
    n_d = p_n - 6'd1;
    v_d = p_v;
    k_d = p_k;
    sfx_d = p_sfx;
    ph = p_sfx ? SUFFIX : PREFIX;
    if (p_md == MD_EGK) begin
      bin_d = e_bin;
      last_d = 1'b0;
      v_d = e_v;
      k_d = e_k;
      n_d = {1'b0, p_k};
      ph = PREFIX;
      md_d = e_done ? MD_BITS : MD_EGK;
      sfx_d = e_done;
    end else if (p_md == MD_UNARY) begin
      bin_d = p_n != 6'd0;
      ph = PREFIX;
      if (p_n != 6'd0) begin
        last_d = p_n == 6'd1 && !p_term && !p_esc;
        md_d = (p_n == 6'd1 && !p_term && p_esc) ? MD_EGK : MD_UNARY;
      end else begin
        last_d = p_sn == 3'd0;
        md_d = MD_BITS;
        n_d = {3'b0, p_sn};
        sfx_d = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    if (load) state_d = ph;
    else if (xfer) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      md_q <= MD_UNARY;
      n_q <= '0;
      v_q <= '0;
      k_q <= '0;
      sn_q <= '0;
      term_q <= 1'b0;
      esc_q <= 1'b0;
      sfx_q <= 1'b0;
      bin_q <= 1'b0;
      last_q <= 1'b0;
      byp_q <= 1'b0;
      ctx_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        term_q <= i_term;
        esc_q <= i_esc;
        sn_q <= i_sn;
        byp_q <= in_binaType == EG1 || in_binaType == CREG || (in_binaType == FL && in_ctxIdx == BYPASS_CTX);
        ctx_q <= in_ctxIdx;
        if (!type_ok) $warning("cabac_bina_serializer: unsupported binaType %0d, element dropped", in_binaType);
      end
      if (load) begin
        md_q <= md_d;
        n_q <= n_d;
        v_q <= v_d;
        k_q <= k_d;
        sfx_q <= sfx_d;
        bin_q <= bin_d;
        last_q <= last_d;
        idx_q <= accept ? '0 : idx_q + BIN_IDX_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_cabac_bina_serializer.sv
// tb_cabac_bina_serializer: directed and randomized checks against a bin-string reference model
module tb_cabac_bina_serializer;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] in_binaType = '0, in_rice = '0;
  logic [3:0] in_cMax = '0;
  logic [8:0] in_ctxIdx = '0;
  logic [15:0] in_value = '0;
  logic in_ready, out_valid, out_bin, out_bypass, out_last;
  logic [8:0] out_ctxIdx;
  logic [5:0] out_binIdx;
  int checks = 0, errors = 0;
  bit exp_q[$];
  bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int types[5] = '{0, 1, 2, 4, 5};

  cabac_bina_serializer #(.VAL_W(16), .BIN_IDX_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_binaType(in_binaType), .in_cMax(in_cMax), .in_ctxIdx(in_ctxIdx),
    .in_value(in_value), .in_rice(in_rice), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_bypass(out_bypass), .out_ctxIdx(out_ctxIdx),
    .out_binIdx(out_binIdx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic push_bits(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(((v >> i) & 1) != 0);
  endtask

  task automatic push_egk(input int v, input int k);
    while (v >= (1 << k)) begin
      exp_q.push_back(1'b1);
      v -= 1 << k;
      k++;
    end
    exp_q.push_back(1'b0);
    push_bits(v, k);
  endtask

  task automatic build_ref(input int t, input int cm, input int v, input int r);
    int u;
    exp_q.delete();
    case (t)
      0: push_bits(v, $clog2(cm + 1));
      1: begin
        u = v < cm ? v : cm;
        repeat (u) exp_q.push_back(1'b1);
        if (u < cm) exp_q.push_back(1'b0);
      end
      2: push_egk(v, 1);
      4: if (v < (4 << r)) begin
        repeat (v >> r) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        push_bits(v, r);
      end else begin
        repeat (4) exp_q.push_back(1'b1);
        push_egk(v - (4 << r), r + 1);
      end
      5: push_bits(v, cm);
      default: ;
    endcase
  endtask

  // mode: <0 fixed ready pattern, otherwise percent chance of stalling each cycle
  task automatic send(input int t, input int cm, input int ctx, input int v, input int r, input int mode);
    int idx = 0, cyc = 0;
    bit byp;
    build_ref(t, cm, v, r);
    byp = (t == 2) || (t == 4) || (t == 0 && ctx == 187);
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_binaType = 3'(t);
    in_cMax = 4'(cm);
    in_ctxIdx = 9'(ctx);
    in_value = 16'(v);
    in_rice = 3'(r);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (idx < exp_q.size() && cyc < 300) begin
      out_ready = mode < 0 ? (cyc < 5 ? pat[cyc] : 1'b1) : ($urandom_range(0, 99) >= mode);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL valid t=%0d v=%0d idx=%0d: out_valid=%b required 1", t, v, idx, out_valid);
      end
      checks++;
      if (out_bin !== exp_q[idx]) begin
        errors++;
        $display("FAIL bin t=%0d cm=%0d v=%0d r=%0d idx=%0d: out_bin=%b required %b", t, cm, v, r, idx, out_bin, exp_q[idx]);
      end
      checks++;
      if (out_binIdx !== 6'(idx)) begin
        errors++;
        $display("FAIL binIdx t=%0d v=%0d: out_binIdx=%0d required %0d", t, v, out_binIdx, idx);
      end
      checks++;
      if (out_last !== (idx == exp_q.size() - 1)) begin
        errors++;
        $display("FAIL last t=%0d v=%0d idx=%0d: out_last=%b required %b", t, v, idx, out_last, idx == exp_q.size() - 1);
      end
      checks++;
      if (out_bypass !== byp) begin
        errors++;
        $display("FAIL bypass t=%0d ctx=%0d: out_bypass=%b required %b", t, ctx, out_bypass, byp);
      end
      checks++;
      if (out_ctxIdx !== 9'(ctx)) begin
        errors++;
        $display("FAIL ctxIdx t=%0d: out_ctxIdx=%0d required %0d", t, out_ctxIdx, ctx);
      end
      if (out_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (idx < exp_q.size()) begin
      errors++;
      $display("FAIL timeout t=%0d v=%0d: transferred=%0d required %0d", t, v, idx, exp_q.size());
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL end_idle t=%0d v=%0d: out_valid=%b in_ready=%b required 0 1", t, v, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_bin, out_bypass, out_ctxIdx, out_binIdx, out_last, in_ready} !== 19'h1) begin
      errors++;
      $display("FAIL reset: v=%b b=%b byp=%b ctx=%0d idx=%0d last=%b rdy=%b required all 0 and rdy 1",
               out_valid, out_bin, out_bypass, out_ctxIdx, out_binIdx, out_last, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tu();
    send(1, 4, 7, 2, 0, 0);
    send(1, 4, 7, 9, 0, 0);
    send(1, 5, 3, 0, 0, 0);
  endtask

  task automatic test_eg1();
    send(2, 0, 50, 5, 0, 0);
    send(2, 0, 50, 0, 0, 0);
    send(2, 0, 51, 1000, 0, 0);
  endtask

  task automatic test_creg();
    send(4, 0, 60, 3, 1, 0);
    send(4, 0, 60, 6, 0, 0);
    send(4, 0, 60, 2, 0, 0);
    send(4, 0, 61, 63, 4, 0);
    send(4, 0, 61, 64, 4, 0);
  endtask

  task automatic test_backpressure();
    send(1, 3, 9, 3, 0, -1);
    send(4, 0, 12, 6, 0, -1);
  endtask

  task automatic test_zero_and_short();
    send(1, 0, 5, 3, 0, 0);
    send(0, 0, 187, 1, 0, 0);
    send(5, 0, 5, 7, 0, 0);
    send(3, 4, 5, 7, 0, 0);
    send(0, 1, 187, 1, 0, 0);
    send(0, 9, 187, 13, 0, 0);
    send(0, 9, 100, 6, 0, 0);
    send(5, 12, 200, 16'hA5C, 0, 0);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_binaType = 3'd2;
    in_cMax = '0;
    in_ctxIdx = 9'd20;
    in_value = 16'd5;
    in_rice = '0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_binIdx !== 6'd1) begin
      errors++;
      $display("FAIL mid_setup: out_valid=%b out_binIdx=%0d required 1 1", out_valid, out_binIdx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_binIdx !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b out_binIdx=%0d required 0 1 0", out_valid, in_ready, out_binIdx);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_resume: out_valid=%b required 0", out_valid);
    end
    send(1, 4, 7, 2, 0, 0);
  endtask

  task automatic test_back_to_back();
    int t, cm, v;
    for (int i = 0; i < 60; i++) begin
      t = types[$urandom_range(0, 4)];
      cm = $urandom_range(0, 15);
      v = (t == 2 || t == 4) && $urandom_range(0, 3) != 0 ? $urandom_range(0, 40) : $urandom_range(0, 65535);
      send(t, cm, $urandom_range(0, 1) ? 187 : $urandom_range(0, 511), v, $urandom_range(0, 4), 30);
    end
  endtask

  initial begin
    test_reset();
    test_tu();
    test_eg1();
    test_creg();
    test_backpressure();
    test_zero_and_short();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
